pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forwarding controller for the 5-stage pipeline.
//  - Drives per-stage stall and flush into the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus a PC hold.
//  - Resolves load-use and RAW hazards, branch/jump redirects and data-memory wait states.
//  - Sits beside the datapath and is fed by the decode, EX, MEM and WB stage fields.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forwarding-select encodings, register address width and the source-match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        RAW_WAIT   = 2'd2,
        MEM_WAIT   = 2'd3
    } hazardState_e;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_SEL_MEMWB   = 2'b01;

    // $0 is hard-wired, so a zero destination never matches a source.
    function automatic logic idReads(input logic [REG_ADDR_LEN-1:0] dest,
                                     input logic [REG_ADDR_LEN-1:0] rsAddr,
                                     input logic                    rsUsed,
                                     input logic [REG_ADDR_LEN-1:0] rtAddr,
                                     input logic                    rtUsed);
        return (dest != '0) && ((rsUsed && (rsAddr == dest)) || (rtUsed && (rtAddr == dest)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding compare for the EX stage ALU operands; the younger MEM result
// wins over the WB result.
module pipeline_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] ex_rs_addr_i,
    input  logic [REG_ADDR_LEN-1:0] ex_rt_addr_i,
    input  logic                    mem_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] mem_write_reg_addr_i,
    input  logic                    wb_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] wb_write_reg_addr_i,
    output logic [1:0]              fwd_a_sel_o,
    output logic [1:0]              fwd_b_sel_o
);

    function automatic logic [1:0] selFor(input logic [REG_ADDR_LEN-1:0] src,
                                          input logic                    memWr,
                                          input logic [REG_ADDR_LEN-1:0] memDest,
                                          input logic                    wbWr,
                                          input logic [REG_ADDR_LEN-1:0] wbDest);
        if (src == '0)                   return FWD_SEL_REGFILE;
        if (memWr && (memDest == src))   return FWD_SEL_EXMEM;
        if (wbWr && (wbDest == src))     return FWD_SEL_MEMWB;
        return FWD_SEL_REGFILE;
    endfunction

    always_comb begin
        fwd_a_sel_o = selFor(ex_rs_addr_i, mem_reg_write_i, mem_write_reg_addr_i,
                             wb_reg_write_i, wb_write_reg_addr_i);
        fwd_b_sel_o = selFor(ex_rt_addr_i, mem_reg_write_i, mem_write_reg_addr_i,
                             wb_reg_write_i, wb_write_reg_addr_i);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Define FWD_EN to enable operand forwarding (only load-use then stalls).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RAW_EX_WAIT  = 2,
    parameter int RAW_MEM_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_LEN-1:0] id_rt_addr_i,
    input  logic                    id_rs_used_i,
    input  logic                    id_rt_used_i,
    input  logic [REG_ADDR_LEN-1:0] ex_rs_addr_i,
    input  logic [REG_ADDR_LEN-1:0] ex_rt_addr_i,
    input  logic                    ex_mem_read_i,
    input  logic                    ex_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] ex_write_reg_addr_i,
    input  logic                    mem_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] mem_write_reg_addr_i,
    input  logic                    wb_reg_write_i,
    input  logic [REG_ADDR_LEN-1:0] wb_write_reg_addr_i,
    input  logic                    branch_taken_i,
    input  logic                    jump_id_i,
    input  logic                    dmem_busy_i,
    output logic                    pc_stall_o,
    output logic                    if_id_stall_o,
    output logic                    id_ex_stall_o,
    output logic                    ex_mem_stall_o,
    output logic                    mem_wb_stall_o,
    output logic                    if_id_flush_o,
    output logic                    id_ex_flush_o,
    output logic                    ex_mem_flush_o,
    output logic [1:0]              fwd_a_sel_o,
    output logic [1:0]              fwd_b_sel_o,
    output logic [1:0]              hazard_state_o
);

    hazardState_e     state_q, state_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic             hazardHit;
    hazardState_e     hazardTarget;
    logic [CNT_W-1:0] hazardCnt;
    logic [1:0]       fwdA, fwdB;

`ifdef FWD_EN
    localparam int unusedWaits = RAW_EX_WAIT + RAW_MEM_WAIT;

    always_comb begin
        hazardHit    = ex_mem_read_i && ex_reg_write_i &&
                       idReads(ex_write_reg_addr_i, id_rs_addr_i, id_rs_used_i,
                               id_rt_addr_i, id_rt_used_i);
        hazardTarget = LOAD_STALL;
        hazardCnt    = '0;
    end

    pipeline_fwd_unit uFwdUnit (
        .ex_rs_addr_i         (ex_rs_addr_i),
        .ex_rt_addr_i         (ex_rt_addr_i),
        .mem_reg_write_i      (mem_reg_write_i),
        .mem_write_reg_addr_i (mem_write_reg_addr_i),
        .wb_reg_write_i       (wb_reg_write_i),
        .wb_write_reg_addr_i  (wb_write_reg_addr_i),
        .fwd_a_sel_o          (fwdA),
        .fwd_b_sel_o          (fwdB)
    );
`else
    logic rawEx, rawMem;
    logic unusedInputs;

    // The detect cycle itself stalls, so a wait of 1 needs no RAW_WAIT visit.
    always_comb begin
        rawEx        = ex_reg_write_i &&
                       idReads(ex_write_reg_addr_i, id_rs_addr_i, id_rs_used_i,
                               id_rt_addr_i, id_rt_used_i);
        rawMem       = mem_reg_write_i &&
                       idReads(mem_write_reg_addr_i, id_rs_addr_i, id_rs_used_i,
                               id_rt_addr_i, id_rt_used_i);
        hazardHit    = rawEx || rawMem;
        hazardCnt    = rawEx ? CNT_W'(RAW_EX_WAIT) : CNT_W'(RAW_MEM_WAIT);
        hazardTarget = (hazardCnt > CNT_W'(1)) ? RAW_WAIT : RUN;
    end

    assign fwdA         = FWD_SEL_REGFILE;
    assign fwdB         = FWD_SEL_REGFILE;
    assign unusedInputs = ^{ex_rs_addr_i, ex_rt_addr_i, ex_mem_read_i,
                            wb_reg_write_i, wb_write_reg_addr_i};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // MEM_WAIT with busy low re-evaluates the frozen pipeline exactly like RUN.
    always_comb begin
        state_d    = state_q;
        stallCnt_d = stallCnt_q;
        if (dmem_busy_i) begin
            state_d = MEM_WAIT;
        end else if (branch_taken_i) begin
            state_d    = RUN;
            stallCnt_d = '0;
        end else begin
            case (state_q)
                RAW_WAIT: begin
                    stallCnt_d = stallCnt_q - CNT_W'(1);
                    if (stallCnt_d <= CNT_W'(1)) begin
                        state_d    = RUN;
                        stallCnt_d = '0;
                    end
                end
                LOAD_STALL: begin
                    state_d = RUN;
                end
                default: begin
                    state_d    = hazardHit ? hazardTarget : RUN;
                    stallCnt_d = (hazardHit && (hazardTarget == RAW_WAIT)) ? hazardCnt : '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (!rst) begin
            if (dmem_busy_i) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_stall_o = 1'b1;
            end else if (branch_taken_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
            end else if ((state_q == RAW_WAIT) ||
                         (((state_q == RUN) || (state_q == MEM_WAIT)) && hazardHit)) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (jump_id_i) begin
                if_id_flush_o  = 1'b1;
            end
        end
    end

    assign fwd_a_sel_o    = rst ? FWD_SEL_REGFILE : fwdA;
    assign fwd_b_sel_o    = rst ? FWD_SEL_REGFILE : fwdB;
    assign hazard_state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; expectations follow
// FWD_EN when the macro is defined for the build.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam logic [7:0] CTRL_NONE   = 8'b00000_000;
    localparam logic [7:0] CTRL_HOLD   = 8'b11000_010;
    localparam logic [7:0] CTRL_BUSY   = 8'b11111_000;
    localparam logic [7:0] CTRL_BRANCH = 8'b00000_111;
    localparam logic [7:0] CTRL_JUMP   = 8'b00000_100;
`ifdef FWD_EN
    localparam logic [1:0] FWD_EXP_MEM   = 2'b10;
    localparam logic [1:0] FWD_EXP_WB    = 2'b01;
    localparam logic [7:0] LOAD_C1_CTRL  = CTRL_NONE;
    localparam logic [1:0] LOAD_C1_STATE = 2'd1;
`else
    localparam logic [1:0] FWD_EXP_MEM   = 2'b00;
    localparam logic [1:0] FWD_EXP_WB    = 2'b00;
    localparam logic [7:0] LOAD_C1_CTRL  = CTRL_HOLD;
    localparam logic [1:0] LOAD_C1_STATE = 2'd2;
`endif

    logic clk, rst;
    logic [4:0] idRsAddr, idRtAddr, exRsAddr, exRtAddr;
    logic [4:0] exWriteRegAddr, memWriteRegAddr, wbWriteRegAddr;
    logic idRsUsed, idRtUsed, exMemRead, exRegWrite, memRegWrite, wbRegWrite;
    logic branchTaken, jumpId, dmemBusy;
    logic pcStall, ifIdStall, idExStall, exMemStall, memWbStall;
    logic ifIdFlush, idExFlush, exMemFlush;
    logic [1:0] fwdA, fwdB, hazState;
    logic [7:0] ctrl;
    int checks = 0;
    int errors = 0;

    assign ctrl = {pcStall, ifIdStall, idExStall, exMemStall, memWbStall,
                   ifIdFlush, idExFlush, exMemFlush};

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs_addr_i(idRsAddr), .id_rt_addr_i(idRtAddr),
        .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed),
        .ex_rs_addr_i(exRsAddr), .ex_rt_addr_i(exRtAddr),
        .ex_mem_read_i(exMemRead), .ex_reg_write_i(exRegWrite),
        .ex_write_reg_addr_i(exWriteRegAddr),
        .mem_reg_write_i(memRegWrite), .mem_write_reg_addr_i(memWriteRegAddr),
        .wb_reg_write_i(wbRegWrite), .wb_write_reg_addr_i(wbWriteRegAddr),
        .branch_taken_i(branchTaken), .jump_id_i(jumpId), .dmem_busy_i(dmemBusy),
        .pc_stall_o(pcStall), .if_id_stall_o(ifIdStall), .id_ex_stall_o(idExStall),
        .ex_mem_stall_o(exMemStall), .mem_wb_stall_o(memWbStall),
        .if_id_flush_o(ifIdFlush), .id_ex_flush_o(idExFlush), .ex_mem_flush_o(exMemFlush),
        .fwd_a_sel_o(fwdA), .fwd_b_sel_o(fwdB), .hazard_state_o(hazState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearInputs();
        idRsAddr = '0; idRtAddr = '0; idRsUsed = 1'b0; idRtUsed = 1'b0;
        exRsAddr = '0; exRtAddr = '0; exMemRead = 1'b0; exRegWrite = 1'b0;
        exWriteRegAddr = '0; memRegWrite = 1'b0; memWriteRegAddr = '0;
        wbRegWrite = 1'b0; wbWriteRegAddr = '0;
        branchTaken = 1'b0; jumpId = 1'b0; dmemBusy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        dmemBusy = 1'b1; branchTaken = 1'b1; jumpId = 1'b1;
        exRsAddr = 5'd4; memRegWrite = 1'b1; memWriteRegAddr = 5'd4;
        #12;
        checks++;
        if ({ctrl, hazState, fwdA, fwdB} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset.outputs got %b want %b", {ctrl, hazState, fwdA, fwdB}, 14'd0);
        end
        clearInputs();
        rst = 1'b0;
        tick();
        checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset.release got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

`ifndef FWD_EN
    task automatic test_raw_ex();
        tick(); clearInputs();
        exRegWrite = 1'b1; exWriteRegAddr = 5'd3; idRsAddr = 5'd3; idRsUsed = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_ex.c0 got %b/%0d want %b/0", ctrl, hazState, CTRL_HOLD);
        end
        tick();
        exRegWrite = 1'b0; exWriteRegAddr = '0; memRegWrite = 1'b1; memWriteRegAddr = 5'd3;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd2}) begin
            errors++; $display("[TB] FAIL raw_ex.c1 got %b/%0d want %b/2", ctrl, hazState, CTRL_HOLD);
        end
        tick();
        memRegWrite = 1'b0; memWriteRegAddr = '0; wbRegWrite = 1'b1; wbWriteRegAddr = 5'd3;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_ex.c2 got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

    task automatic test_raw_mem();
        tick(); clearInputs();
        memRegWrite = 1'b1; memWriteRegAddr = 5'd3; idRtAddr = 5'd3; idRtUsed = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_mem.c0 got %b/%0d want %b/0", ctrl, hazState, CTRL_HOLD);
        end
        tick();
        memRegWrite = 1'b0; memWriteRegAddr = '0; wbRegWrite = 1'b1; wbWriteRegAddr = 5'd3;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_mem.c1 got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
        tick(); clearInputs();
        memRegWrite = 1'b1; memWriteRegAddr = 5'd3; idRtAddr = 5'd3; idRtUsed = 1'b0;
        #1; checks++;
        if (ctrl !== CTRL_NONE) begin
            errors++; $display("[TB] FAIL raw_mem.unused_src got %b want %b", ctrl, CTRL_NONE);
        end
        tick(); clearInputs();
        exRegWrite = 1'b1; memRegWrite = 1'b1; idRsUsed = 1'b1; idRtUsed = 1'b1;
        #1; checks++;
        if (ctrl !== CTRL_NONE) begin
            errors++; $display("[TB] FAIL raw_mem.reg_zero got %b want %b", ctrl, CTRL_NONE);
        end
    endtask

    task automatic test_raw_priority();
        tick(); clearInputs();
        exRegWrite = 1'b1; exWriteRegAddr = 5'd3; idRsAddr = 5'd3; idRsUsed = 1'b1;
        memRegWrite = 1'b1; memWriteRegAddr = 5'd5; idRtAddr = 5'd5; idRtUsed = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_prio.c0 got %b/%0d want %b/0", ctrl, hazState, CTRL_HOLD);
        end
        tick();
        exRegWrite = 1'b0; exWriteRegAddr = '0; memWriteRegAddr = 5'd3;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd2}) begin
            errors++; $display("[TB] FAIL raw_prio.c1 got %b/%0d want %b/2", ctrl, hazState, CTRL_HOLD);
        end
        tick(); clearInputs();
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL raw_prio.c2 got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

    task automatic test_branch_during_raw();
        tick(); clearInputs();
        exRegWrite = 1'b1; exWriteRegAddr = 5'd3; idRsAddr = 5'd3; idRsUsed = 1'b1;
        tick();
        exRegWrite = 1'b0; exWriteRegAddr = '0; memRegWrite = 1'b1; memWriteRegAddr = 5'd3;
        branchTaken = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_BRANCH, 2'd2}) begin
            errors++; $display("[TB] FAIL branch_raw.c1 got %b/%0d want %b/2", ctrl, hazState, CTRL_BRANCH);
        end
        tick(); clearInputs();
        #1; checks++;
        if ({ctrl, hazState, dut.stallCnt_q} !== {CTRL_NONE, 2'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL branch_raw.c2 got %b/%0d cnt %0d want %b/0 cnt 0",
                     ctrl, hazState, dut.stallCnt_q, CTRL_NONE);
        end
    endtask
`endif

    task automatic test_dmem_busy();
        logic [1:0] expState;
        tick(); clearInputs();
        dmemBusy = 1'b1; branchTaken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            expState = (c == 0) ? 2'd0 : 2'd3;
            #1; checks++;
            if ({ctrl, hazState} !== {CTRL_BUSY, expState}) begin
                errors++;
                $display("[TB] FAIL busy.c%0d got %b/%0d want %b/%0d", c, ctrl, hazState, CTRL_BUSY, expState);
            end
            tick();
        end
        dmemBusy = 1'b0;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_BRANCH, 2'd3}) begin
            errors++; $display("[TB] FAIL busy.c3 got %b/%0d want %b/3", ctrl, hazState, CTRL_BRANCH);
        end
        tick(); clearInputs();
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL busy.c4 got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

    task automatic test_load_use();
        tick(); clearInputs();
        exMemRead = 1'b1; exRegWrite = 1'b1; exWriteRegAddr = 5'd2; idRsAddr = 5'd2; idRsUsed = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_HOLD, 2'd0}) begin
            errors++; $display("[TB] FAIL load_use.c0 got %b/%0d want %b/0", ctrl, hazState, CTRL_HOLD);
        end
        tick();
        exMemRead = 1'b0; exRegWrite = 1'b0; exWriteRegAddr = '0;
        memRegWrite = 1'b1; memWriteRegAddr = 5'd2;
        #1; checks++;
        if ({ctrl, hazState} !== {LOAD_C1_CTRL, LOAD_C1_STATE}) begin
            errors++;
            $display("[TB] FAIL load_use.c1 got %b/%0d want %b/%0d", ctrl, hazState, LOAD_C1_CTRL, LOAD_C1_STATE);
        end
        tick(); clearInputs();
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL load_use.c2 got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

    task automatic test_jump();
        tick(); clearInputs();
        jumpId = 1'b1;
        #1; checks++;
        if ({ctrl, hazState} !== {CTRL_JUMP, 2'd0}) begin
            errors++; $display("[TB] FAIL jump.alone got %b/%0d want %b/0", ctrl, hazState, CTRL_JUMP);
        end
        tick();
        exMemRead = 1'b1; exRegWrite = 1'b1; exWriteRegAddr = 5'd6; idRtAddr = 5'd6; idRtUsed = 1'b1;
        #1; checks++;
        if (ctrl !== CTRL_HOLD) begin
            errors++; $display("[TB] FAIL jump.during_stall got %b want %b", ctrl, CTRL_HOLD);
        end
        tick();
        exMemRead = 1'b0; exRegWrite = 1'b0; exWriteRegAddr = '0;
        memRegWrite = 1'b1; memWriteRegAddr = 5'd6;
`ifndef FWD_EN
        #1; checks++;
        if (ctrl !== CTRL_HOLD) begin
            errors++; $display("[TB] FAIL jump.held got %b want %b", ctrl, CTRL_HOLD);
        end
        tick();
        memRegWrite = 1'b0; memWriteRegAddr = '0;
`endif
        #1; checks++;
        if (ctrl !== CTRL_JUMP) begin
            errors++; $display("[TB] FAIL jump.released got %b want %b", ctrl, CTRL_JUMP);
        end
        tick(); clearInputs();
    endtask

    task automatic test_forwarding();
        tick(); clearInputs();
        exRsAddr = 5'd4; exRtAddr = 5'd7;
        memRegWrite = 1'b1; memWriteRegAddr = 5'd4; wbRegWrite = 1'b1; wbWriteRegAddr = 5'd4;
        #1; checks++;
        if ({fwdA, fwdB} !== {FWD_EXP_MEM, 2'b00}) begin
            errors++; $display("[TB] FAIL fwd.mem_over_wb got %b/%b want %b/00", fwdA, fwdB, FWD_EXP_MEM);
        end
        exRsAddr = '0; exRtAddr = '0; memWriteRegAddr = '0; wbWriteRegAddr = '0;
        #1; checks++;
        if ({fwdA, fwdB} !== 4'b0000) begin
            errors++; $display("[TB] FAIL fwd.reg_zero got %b/%b want 00/00", fwdA, fwdB);
        end
        exRsAddr = 5'd4; exRtAddr = 5'd7; memWriteRegAddr = 5'd9; wbWriteRegAddr = 5'd7;
        #1; checks++;
        if ({fwdA, fwdB} !== {2'b00, FWD_EXP_WB}) begin
            errors++; $display("[TB] FAIL fwd.wb_only got %b/%b want 00/%b", fwdA, fwdB, FWD_EXP_WB);
        end
        tick(); clearInputs();
    endtask

    task automatic test_reset_midstall();
        tick(); clearInputs();
        exMemRead = 1'b1; exRegWrite = 1'b1; exWriteRegAddr = 5'd2; idRsAddr = 5'd2; idRsUsed = 1'b1;
        tick();
        exMemRead = 1'b0; exRegWrite = 1'b0; exWriteRegAddr = '0;
        #1; checks++;
        if (hazState !== LOAD_C1_STATE) begin
            errors++; $display("[TB] FAIL rst_mid.entry got %0d want %0d", hazState, LOAD_C1_STATE);
        end
        rst = 1'b1; dmemBusy = 1'b1;
        #1; checks++;
        if ({ctrl, hazState, fwdA, fwdB} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid.async got %b want %b", {ctrl, hazState, fwdA, fwdB}, 14'd0);
        end
        #2; rst = 1'b0; clearInputs();
        tick();
        checks++;
        if ({ctrl, hazState} !== {CTRL_NONE, 2'd0}) begin
            errors++; $display("[TB] FAIL rst_mid.release got %b/%0d want %b/0", ctrl, hazState, CTRL_NONE);
        end
    endtask

    initial begin
        test_reset();
`ifndef FWD_EN
        test_raw_ex();
        test_raw_mem();
        test_raw_priority();
        test_branch_during_raw();
`endif
        test_dmem_busy();
        test_load_use();
        test_jump();
        test_forwarding();
        test_reset_midstall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
